// File: rtl/target_hit_judge.sv
// ============================================================================
// Module   : target_hit_judge
// Brief    : Reaction-game round controller; scores synchronized switch rises
//            against a target mask with a per-round timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module target_hit_judge #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear_score,
  input  logic [17:0]        led_mask,
  input  logic [17:0]        sw,
  output logic               step,
  output logic [17:0]        led_out,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic               round_done,
  output logic               busy
);

  localparam int                 c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_ARMED = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [17:0]          r_sw_meta;
  logic [17:0]          r_sw_sync;
  logic [17:0]          r_sw_dly;
  logic [17:0]          r_target;
  logic [c_cnt_w-1:0]   r_count;
  logic [SCORE_W-1:0]   r_hits;
  logic [SCORE_W-1:0]   r_misses;

  logic [17:0]          w_rise;
  logic [17:0]          w_hit_bits;
  logic [17:0]          w_miss_bits;
  logic [17:0]          w_remaining;
  logic                 w_timeout;
  logic [4:0]           w_hit_add;
  logic [4:0]           w_miss_add;

  function automatic logic [4:0] f_popcount(input logic [17:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 18; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // The whole cycle's total goes through one add so saturation is exact.
  function automatic logic [SCORE_W-1:0] f_sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [4:0]         b);
    logic [SCORE_W+4:0] s;
    s = {5'd0, a} + {{SCORE_W{1'b0}}, b};
    if (s > {5'd0, {SCORE_W{1'b1}}}) begin
      return {SCORE_W{1'b1}};
    end
    return s[SCORE_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_dly  <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_sw_dly  <= r_sw_sync;
    end
  end

  assign w_rise      = r_sw_sync & ~r_sw_dly;
  assign w_hit_bits  = w_rise & r_target;
  assign w_miss_bits = w_rise & ~r_target;
  assign w_remaining = r_target & ~w_hit_bits;
  assign w_timeout   = (r_count == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hit_add    = '0;
    w_miss_add   = '0;
    case (r_state)
      S_IDLE:  if (run) w_state_next = S_REQ;
      S_REQ:   w_state_next = S_LOAD;
      S_LOAD:  w_state_next = (led_mask == '0) ? S_DONE : S_ARMED;
      S_ARMED: begin
        w_hit_add  = f_popcount(w_hit_bits);
        w_miss_add = f_popcount(w_miss_bits);
        if (w_remaining == '0) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          // Targets still lit when time runs out are scored as misses.
          w_state_next = S_DONE;
          w_miss_add   = f_popcount(w_miss_bits) + f_popcount(w_remaining);
        end
      end
      S_DONE:  w_state_next = run ? S_REQ : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_count  <= '0;
    end else if (r_state == S_LOAD) begin
      r_target <= led_mask;
      r_count  <= '0;
    end else if (r_state == S_ARMED) begin
      r_target <= w_remaining;
      r_count  <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (clear_score) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_hits   <= f_sat_add(r_hits, w_hit_add);
      r_misses <= f_sat_add(r_misses, w_miss_add);
    end
  end

  assign step       = (r_state == S_REQ);
  assign round_done = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign led_out    = (r_state == S_ARMED) ? r_target : '0;
  assign hits       = r_hits;
  assign misses     = r_misses;

endmodule

`default_nettype wire

// File: tb/tb_target_hit_judge.sv
// ============================================================================
// Module   : tb_target_hit_judge
// Brief    : Directed and randomized bench for target_hit_judge with an
//            in-bench round-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_target_hit_judge;

  localparam int c_t   = 16;
  localparam int c_max = 255;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_LOAD  = 2;
  localparam int P_ARMED = 3;
  localparam int P_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        clear_score;
  logic [17:0] led_mask;
  logic [17:0] sw;
  logic        step;
  logic [17:0] led_out;
  logic [7:0]  hits;
  logic [7:0]  misses;
  logic        round_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  int          m_phase = P_IDLE;
  int          m_cnt   = 0;
  int          m_hits  = 0;
  int          m_miss  = 0;
  logic [17:0] m_tgt   = '0;
  logic [17:0] h1 = '0, h2 = '0, h3 = '0;

  target_hit_judge #(.TIMEOUT_CYCLES(c_t), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear_score(clear_score),
    .led_mask(led_mask), .sw(sw), .step(step), .led_out(led_out),
    .hits(hits), .misses(misses), .round_done(round_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference: each clock edge advances the round by the game rules; a switch
  // change reaches the judge two edges later as a rise.
  always @(posedge clk) begin : b_model
    logic [17:0] rise, hit, rem;
    int ah, am;
    if (!rst_n) begin
      m_phase = P_IDLE; m_cnt = 0; m_hits = 0; m_miss = 0; m_tgt = '0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = sw;
      ah = 0; am = 0;
      case (m_phase)
        P_IDLE:  if (run) m_phase = P_REQ;
        P_REQ:   m_phase = P_LOAD;
        P_LOAD: begin
          m_tgt = led_mask; m_cnt = 0;
          m_phase = (led_mask == 0) ? P_DONE : P_ARMED;
        end
        P_ARMED: begin
          hit = rise & m_tgt;
          rem = m_tgt & ~hit;
          ah = $countones(hit);
          am = $countones(rise & ~m_tgt);
          m_tgt = rem;
          if (rem == 0) m_phase = P_DONE;
          else if (m_cnt == c_t - 1) begin
            am = am + $countones(rem);
            m_phase = P_DONE;
          end
          m_cnt++;
        end
        default: m_phase = run ? P_REQ : P_IDLE;
      endcase
      m_hits = clear_score ? 0 : ((m_hits + ah > c_max) ? c_max : m_hits + ah);
      m_miss = clear_score ? 0 : ((m_miss + am > c_max) ? c_max : m_miss + am);
    end
    #1;
    check("step",       step,       m_phase == P_REQ);
    check("round_done", round_done, m_phase == P_DONE);
    check("busy",       busy,       m_phase != P_IDLE);
    check("led_out",    led_out,    (m_phase == P_ARMED) ? m_tgt : 18'h0);
    check("hits",       hits,       m_hits);
    check("misses",     misses,     m_miss);
  end

  task automatic wait_armed();
    int k = 0;
    while (led_out == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (led_out == '0) begin
      n_vec++; n_err++;
      $display("FAIL wait_armed: led_out stayed 0 expected nonzero");
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!round_done && n < 60);
    if (!round_done) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: round_done 0 expected 1");
    end
  endtask

  task automatic go_idle();
    int k = 0;
    run = 1'b0;
    @(negedge clk);
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL go_idle: busy 1 expected 0");
    end
  endtask

  task automatic pulse_clear();
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, steps;
    logic [17:0] m;
    rst_n = 1'b0; run = 1'b0; clear_score = 1'b0; led_mask = '0; sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hits", hits, 0);
    check("reset_led",  led_out, 0);

    // Two targets hit in turn, run held so the next round starts at once.
    led_mask = 18'h00005; run = 1'b1;
    wait_armed();
    sw[0] = 1'b1;
    repeat (4) @(negedge clk);
    sw[2] = 1'b1;
    wait_done(n);
    check("t1_hits", hits, 2);
    check("t1_misses", misses, 0);
    check("t1_model_hits", m_hits, 2);
    @(negedge clk);
    check("t1_step_after_done", step, 1);
    go_idle();
    sw = '0;
    pulse_clear();

    // One wrong toggle then timeout with two targets left.
    led_mask = 18'h00208; run = 1'b1;
    wait_armed();
    sw[4] = 1'b1; run = 1'b0;
    wait_done(n);
    check("t2_armed_len", n, 16);
    check("t2_hits", hits, 0);
    check("t2_misses", misses, 3);
    check("t2_model_misses", m_miss, 3);
    go_idle();
    sw = '0;
    pulse_clear();

    // Both targets in one cycle.
    led_mask = 18'h00022; run = 1'b1;
    wait_armed();
    sw = 18'h00022; run = 1'b0;
    wait_done(n);
    check("t3a_len", n, 3);
    check("t3a_hits", hits, 2);
    go_idle();
    sw = '0;
    pulse_clear();

    // Last target cleared on the final ARMED cycle counts as a hit.
    run = 1'b1;
    wait_armed();
    sw[1] = 1'b1; run = 1'b0;
    repeat (13) @(negedge clk);
    sw[5] = 1'b1;
    wait_done(n);
    check("t3b_len", n, 3);
    check("t3b_hits", hits, 2);
    check("t3b_misses", misses, 0);
    go_idle();
    sw = '0;
    pulse_clear();

    // Saturation, then clear on a hit cycle.
    for (int r = 0; r < 15; r++) begin
      led_mask = '1; run = 1'b1;
      wait_armed();
      sw = '1; run = 1'b0;
      wait_done(n);
      go_idle();
      sw = '0;
    end
    check("t4_model_sat", m_hits, 255);
    check("t4_sat", hits, 255);
    led_mask = 18'h00001; run = 1'b1;
    wait_armed();
    sw[0] = 1'b1; run = 1'b0;
    wait_done(n);
    check("t4_sat_hold", hits, 255);
    go_idle();
    sw = '0;
    run = 1'b1;
    wait_armed();
    sw[0] = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    check("t4_clear_on_hit", hits, 0);
    go_idle();
    sw = '0;

    // Reset in the middle of a round.
    led_mask = 18'h00300; run = 1'b1;
    wait_armed();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_led", led_out, 0);
    check("t5_busy", busy, 0);
    check("t5_done", round_done, 0);
    check("t5_misses", misses, 0);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_idle", busy, 0);

    // Switch activity while idle changes nothing.
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      sw = 18'($urandom);
      @(negedge clk);
      if (step) steps++;
    end
    check("t6_steps", steps, 0);
    check("t6_hits", hits, 0);
    check("t6_misses", misses, 0);

    // Randomized play.
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom % 4) != 0;
      m = '0;
      case ($urandom % 16)
        0:       m = '0;
        1:       m = 18'($urandom);
        default: begin
          m[$urandom % 18] = 1'b1;
          m[$urandom % 18] = 1'b1;
        end
      endcase
      led_mask = m;
      if ($urandom % 3 == 0) sw[$urandom % 18] = ~sw[$urandom % 18];
      clear_score = ($urandom % 60) == 0;
      @(negedge clk);
    end
    clear_score = 1'b0;
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
